// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, counter types and sync-monitor state encoding.
package vga_timing_pkg;

  localparam int unsigned CNT_W  = 12;
  localparam int unsigned GOOD_W = 4;

  localparam int unsigned DEF_H_SYNC      = 96;
  localparam int unsigned DEF_H_BACK      = 48;
  localparam int unsigned DEF_H_ACTIVE    = 640;
  localparam int unsigned DEF_H_TOTAL     = 800;
  localparam int unsigned DEF_V_SYNC      = 2;
  localparam int unsigned DEF_V_BACK      = 33;
  localparam int unsigned DEF_V_ACTIVE    = 480;
  localparam int unsigned DEF_V_TOTAL     = 525;
  localparam int unsigned DEF_LOCK_FRAMES = 2;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [CNT_W:0]    len_t;
  typedef logic [GOOD_W-1:0] good_t;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Samples an active-low sync on each pixel strobe and flags its falling edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_en,
  input  logic sync_in,
  output logic fall_c
);

  logic prev;

  // Previous sampled level; resets high so a sync held low at reset is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= 1'b1;
    end else if (pix_en) begin
      prev <= sync_in;
    end
  end

  assign fall_c = pix_en & ~sync_in & prev;

endmodule

// File: rtl/vga_sync_monitor.sv
// Recovers pixel position from HS/VS, measures line/frame lengths and tracks lock.
module vga_sync_monitor
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
  parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             PIX_EN,
  input  logic             HS,
  input  logic             VS,
  output logic [CNT_W-1:0] X,
  output logic [CNT_W-1:0] Y,
  output logic             ACTIVE,
  output logic             LOCKED,
  output logic             FRAME_START,
  output logic             ERR,
  output logic [CNT_W-1:0] H_MEAS,
  output logic [CNT_W-1:0] V_MEAS
);

  localparam cnt_t  X_LO    = cnt_t'(H_SYNC + H_BACK);
  localparam cnt_t  X_HI    = cnt_t'(H_SYNC + H_BACK + H_ACTIVE);
  localparam cnt_t  Y_LO    = cnt_t'(V_SYNC + V_BACK);
  localparam cnt_t  Y_HI    = cnt_t'(V_SYNC + V_BACK + V_ACTIVE);
  localparam len_t  H_LEN   = len_t'(H_TOTAL);
  localparam len_t  V_LEN   = len_t'(V_TOTAL);
  localparam good_t LOCK_N  = good_t'(LOCK_FRAMES);
  localparam cnt_t  CNT_SAT = '1;

  sync_state_t state, state_nx;
  good_t       good, good_nx;
  cnt_t        hcnt, vcnt, hcnt_nx, vcnt_nx;
  cnt_t        x_nx, y_nx;
  len_t        h_len_c, v_len_c;
  logic        vs_pend, line_bad;
  logic        line_edge_c, vs_fall_c, boundary_c;
  logic        cur_line_bad_c, frame_good_c, sat_c;
  logic        err_c, fs_c;
  logic        locked_nx, active_nx, in_x, in_y;

  sync_edge_det u_hs_edge (
    .clk    (CLOCK_50),
    .rst_n  (RESET_N),
    .pix_en (PIX_EN),
    .sync_in(HS),
    .fall_c (line_edge_c)
  );

  sync_edge_det u_vs_edge (
    .clk    (CLOCK_50),
    .rst_n  (RESET_N),
    .pix_en (PIX_EN),
    .sync_in(VS),
    .fall_c (vs_fall_c)
  );

  // Line/frame edge classification and length checks of the line or frame just ending.
  always_comb begin
    boundary_c     = line_edge_c & (vs_pend | vs_fall_c);
    h_len_c        = len_t'(hcnt) + len_t'(1);
    v_len_c        = len_t'(vcnt) + len_t'(1);
    cur_line_bad_c = (h_len_c != H_LEN);
    frame_good_c   = (v_len_c == V_LEN) && !line_bad && !cur_line_bad_c;
  end

  // Next counter values; hold when no strobe, saturate at the counter ceiling.
  always_comb begin
    hcnt_nx = hcnt;
    vcnt_nx = vcnt;
    if (PIX_EN) begin
      if (line_edge_c) begin
        hcnt_nx = '0;
      end else if (hcnt != CNT_SAT) begin
        hcnt_nx = hcnt + cnt_t'(1);
      end
      if (boundary_c) begin
        vcnt_nx = '0;
      end else if (line_edge_c && (vcnt != CNT_SAT)) begin
        vcnt_nx = vcnt + cnt_t'(1);
      end
    end
    sat_c = PIX_EN && (hcnt_nx == CNT_SAT);
  end

  // Lock state machine: next state, good-frame count and ERR/FRAME_START pulses.
  always_comb begin
    state_nx = state;
    good_nx  = good;
    err_c    = 1'b0;
    fs_c     = 1'b0;
    if (PIX_EN) begin
      case (state)
        ST_SEARCH: begin
          if (boundary_c) begin
            state_nx = ST_ACQUIRE;
            good_nx  = '0;
          end
        end
        ST_ACQUIRE: begin
          if (boundary_c) begin
            if (frame_good_c) begin
              good_nx = good + good_t'(1);
              if ((good + good_t'(1)) == LOCK_N) begin
                state_nx = ST_LOCKED;
                fs_c     = 1'b1;
              end
            end else begin
              good_nx = '0;
            end
          end
        end
        ST_LOCKED: begin
          if ((line_edge_c && cur_line_bad_c) || (boundary_c && !frame_good_c)) begin
            state_nx = ST_SEARCH;
            err_c    = 1'b1;
          end else if (boundary_c) begin
            fs_c = 1'b1;
          end
        end
        default: begin
          state_nx = ST_SEARCH;
        end
      endcase
      if (sat_c) begin
        state_nx = ST_SEARCH;
        fs_c     = 1'b0;
        err_c    = (state == ST_LOCKED);
      end
    end
  end

  // Recovered position for the pixel being sampled this strobe.
  always_comb begin
    locked_nx = (state_nx == ST_LOCKED);
    in_x      = (hcnt_nx >= X_LO) && (hcnt_nx < X_HI);
    in_y      = (vcnt_nx >= Y_LO) && (vcnt_nx < Y_HI);
    active_nx = locked_nx && in_x && in_y;
    x_nx      = active_nx ? (hcnt_nx - X_LO) : '0;
    y_nx      = active_nx ? (vcnt_nx - Y_LO) : '0;
  end

  // State register and good-frame counter.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state <= ST_SEARCH;
      good  <= '0;
    end else begin
      state <= state_nx;
      good  <= good_nx;
    end
  end

  // Counters, measurements, line-error tracking and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      hcnt        <= '0;
      vcnt        <= '0;
      vs_pend     <= 1'b0;
      line_bad    <= 1'b0;
      H_MEAS      <= '0;
      V_MEAS      <= '0;
      X           <= '0;
      Y           <= '0;
      ACTIVE      <= 1'b0;
      LOCKED      <= 1'b0;
      FRAME_START <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      FRAME_START <= fs_c;
      ERR         <= err_c;
      if (PIX_EN) begin
        hcnt   <= hcnt_nx;
        vcnt   <= vcnt_nx;
        X      <= x_nx;
        Y      <= y_nx;
        ACTIVE <= active_nx;
        LOCKED <= locked_nx;
        if (line_edge_c) begin
          H_MEAS <= cnt_t'(h_len_c);
        end
        if (boundary_c) begin
          V_MEAS   <= cnt_t'(v_len_c);
          vs_pend  <= 1'b0;
          line_bad <= 1'b0;
        end else begin
          if (vs_fall_c) begin
            vs_pend <= 1'b1;
          end
          if (line_edge_c && cur_line_bad_c) begin
            line_bad <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a reduced 32x16 raster.
module tb_vga_sync_monitor;
  import vga_timing_pkg::*;

  // Reduced raster: HS low 4, back porch 4, 16 active of 32; VS low 2, back 3, 8 active of 16.
  localparam int HT = 32;
  localparam int VT = 16;
  localparam int XL = 8;
  localparam int XH = 24;
  localparam int YL = 5;
  localparam int YH = 13;

  logic             CLOCK_50;
  logic             RESET_N;
  logic             PIX_EN;
  logic             HS;
  logic             VS;
  logic [CNT_W-1:0] X;
  logic [CNT_W-1:0] Y;
  logic             ACTIVE;
  logic             LOCKED;
  logic             FRAME_START;
  logic             ERR;
  logic [CNT_W-1:0] H_MEAS;
  logic [CNT_W-1:0] V_MEAS;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int fs_cnt   = 0;
  int base;

  vga_sync_monitor #(
    .H_SYNC(4), .H_BACK(4), .H_ACTIVE(16), .H_TOTAL(HT),
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(8), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .PIX_EN     (PIX_EN),
    .HS         (HS),
    .VS         (VS),
    .X          (X),
    .Y          (Y),
    .ACTIVE     (ACTIVE),
    .LOCKED     (LOCKED),
    .FRAME_START(FRAME_START),
    .ERR        (ERR),
    .H_MEAS     (H_MEAS),
    .V_MEAS     (V_MEAS)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Pulse counters.
  always @(negedge CLOCK_50) begin
    if (ERR) err_cnt++;
    if (FRAME_START) fs_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic hs_of(input int p);
    return (p < 4) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic vs_of(input int l);
    return (l < 2) ? 1'b0 : 1'b1;
  endfunction

  // One idle cycle, then one strobed pixel; returns at the negedge after it was sampled.
  task automatic pix(input logic h, input logic v);
    @(negedge CLOCK_50);
    PIX_EN = 1'b1;
    HS     = h;
    VS     = v;
    @(negedge CLOCK_50);
    PIX_EN = 1'b0;
  endtask

  task automatic chk_px(input int l, input int p, input logic lk);
    logic act;
    act = lk && (p >= XL) && (p < XH) && (l >= YL) && (l < YH);
    chk("active", 32'(ACTIVE), 32'(act));
    chk("x", 32'(X), act ? 32'(p - XL) : 32'd0);
    chk("y", 32'(Y), act ? 32'(l - YL) : 32'd0);
  endtask

  task automatic run_line(input int l, input int len, input logic lk, input logic fs0,
                          input logic e0, input logic pause);
    for (int p = 0; p < len; p++) begin
      pix(hs_of(p), vs_of(l));
      chk_px(l, p, lk);
      if (p == 0) begin
        chk("locked", 32'(LOCKED), 32'(lk));
        chk("frame_start", 32'(FRAME_START), (l == 0) ? 32'(fs0) : 32'd0);
        chk("err", 32'(ERR), 32'(e0));
        if (e0) chk("h_meas_bad", 32'(H_MEAS), 32'd33);
      end
      if (pause && (p == 11)) begin
        repeat (50) @(negedge CLOCK_50);
        chk_px(l, p, lk);
        chk("locked_hold", 32'(LOCKED), 32'(lk));
      end
    end
  endtask

  task automatic run_frame(input int nlines, input int bad_line, input int pause_line,
                           input logic lk, input logic fs0);
    for (int l = 0; l < nlines; l++) begin
      run_line(l, (l == bad_line) ? 33 : HT,
               (bad_line >= 0 && l > bad_line) ? 1'b0 : lk,
               fs0,
               (bad_line >= 0 && l == bad_line + 1),
               (l == pause_line));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_x"}, 32'(X), 32'd0);
    chk({tag, "_y"}, 32'(Y), 32'd0);
    chk({tag, "_active"}, 32'(ACTIVE), 32'd0);
    chk({tag, "_locked"}, 32'(LOCKED), 32'd0);
    chk({tag, "_fs"}, 32'(FRAME_START), 32'd0);
    chk({tag, "_err"}, 32'(ERR), 32'd0);
    chk({tag, "_hmeas"}, 32'(H_MEAS), 32'd0);
    chk({tag, "_vmeas"}, 32'(V_MEAS), 32'd0);
  endtask

  initial begin
    RESET_N = 1'b0;
    PIX_EN  = 1'b0;
    HS      = 1'b1;
    VS      = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk_reset_outputs("reset");
    RESET_N = 1'b1;

    // Acquisition: boundary 1 enters ACQUIRE, boundary 2 is the first good frame.
    run_frame(VT, -1, -1, 1'b0, 1'b0);
    run_frame(VT, -1, -1, 1'b0, 1'b0);
    chk("h_meas_nom", 32'(H_MEAS), 32'(HT));
    chk("v_meas_nom", 32'(V_MEAS), 32'(VT));
    chk("unlocked_before_b3", 32'(LOCKED), 32'd0);

    // Boundary 3 locks; second locked frame pauses PIX_EN mid-line.
    base = fs_cnt;
    run_frame(VT, -1, -1, 1'b1, 1'b1);
    run_frame(VT, -1, 6, 1'b1, 1'b1);
    chk("fs_per_frame", 32'(fs_cnt - base), 32'd2);
    chk("no_err_nominal", 32'(err_cnt), 32'd0);

    // One 33-pixel line breaks lock; relock on the third boundary after it.
    base = err_cnt;
    run_frame(VT, 7, -1, 1'b1, 1'b1);
    chk("err_once_bad_line", 32'(err_cnt - base), 32'd1);
    run_frame(VT, -1, -1, 1'b0, 1'b0);
    run_frame(VT, -1, -1, 1'b0, 1'b0);
    run_frame(VT, -1, -1, 1'b1, 1'b1);

    // Reset for one cycle mid-frame while locked.
    for (int l = 0; l < 8; l++) run_line(l, HT, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge CLOCK_50);
    RESET_N = 1'b0;
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    chk_reset_outputs("midreset");
    for (int l = 8; l < VT; l++) run_line(l, HT, 1'b0, 1'b0, 1'b0, 1'b0);
    // Short frame during acquisition resets the good count, delaying lock one frame.
    run_frame(VT - 1, -1, -1, 1'b0, 1'b0);
    run_frame(VT, -1, -1, 1'b0, 1'b0);
    chk("v_meas_short", 32'(V_MEAS), 32'(VT - 1));
    run_frame(VT, -1, -1, 1'b0, 1'b0);
    chk("v_meas_after_short", 32'(V_MEAS), 32'(VT));
    run_frame(VT, -1, -1, 1'b1, 1'b1);

    // HS stuck high while locked: counter saturation drops lock.
    for (int l = 0; l < 3; l++) run_line(l, HT, 1'b1, 1'b1, 1'b0, 1'b0);
    base = err_cnt;
    repeat (4096) pix(1'b1, 1'b1);
    repeat (2) @(negedge CLOCK_50);
    chk("err_once_sat", 32'(err_cnt - base), 32'd1);
    chk("locked_sat", 32'(LOCKED), 32'd0);
    chk("active_sat", 32'(ACTIVE), 32'd0);
    chk("state_sat", 32'(dut.state), 32'(ST_SEARCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side counterpart of the VGA timing generator. Samples the HS/VS sync pair on each pixel strobe, recovers the horizontal/vertical position, measures line and frame lengths, and declares lock once timing is stable. The recovered X/Y/ACTIVE feed in-system checkers and capture logic.

## Interface
- H_SYNC, 96: HS low width in pixels (informational; not checked).
- H_BACK, 48: back porch; active X starts at hcnt = H_SYNC+H_BACK.
- H_ACTIVE, 640: visible pixels per line.
- H_TOTAL, 800: expected pixels per line.
- V_SYNC, 2: VS low width in lines (informational).
- V_BACK, 33: vertical back porch; active Y starts at vcnt = V_SYNC+V_BACK.
- V_ACTIVE, 480: visible lines.
- V_TOTAL, 525: expected lines per frame.
- LOCK_FRAMES, 2: consecutive good frames required to lock (1..15).
- CLOCK_50 in 1: sole clock. All logic is on its rising edge.
- RESET_N in 1: reset, synchronous, active-low.
- PIX_EN in 1: pixel strobe. HS/VS are sampled only when high.
- HS in 1: horizontal sync, active low.
- VS in 1: vertical sync, active low.
- X out 12: active column, 0..H_ACTIVE-1. Forced to 0 when ACTIVE=0.
- Y out 12: active row, 0..V_ACTIVE-1. Forced to 0 when ACTIVE=0.
- ACTIVE out 1: inside the visible window and LOCKED.
- LOCKED out 1: timing locked.
- FRAME_START out 1: one-cycle pulse on each frame boundary while locked.
- ERR out 1: one-cycle pulse when lock is lost.
- H_MEAS out 12: length of the last completed line.
- V_MEAS out 12: length of the last completed frame.

## Operation
- Reset: all outputs are 0. hcnt=vcnt=0, hs_prev=vs_prev=1, vs_pend=0, good=0, line_bad=0, state SEARCH.
- Nothing changes on cycles with PIX_EN=0, except that FRAME_START and ERR return to 0.
- **Line edge:** sampled HS=0 while hs_prev=1.
  - H_MEAS <= hcnt+1 and hcnt <= 0.
  - Otherwise hcnt increments, saturating at 4095.
- **VS fall:** sampled VS=0 while vs_prev=1. Sets vs_pend.
- **Frame boundary:** a line edge with vs_pend set, or with a VS fall on the same pixel.
  - V_MEAS <= vcnt+1, vcnt <= 0, vs_pend cleared.
  - A non-boundary line edge increments vcnt, saturating at 4095.
- **Line check:** at each line edge, line_bad is set if hcnt+1 ≠ H_TOTAL. line_bad clears at each frame boundary.
- **State machine:**
  - SEARCH → ACQUIRE on the first frame boundary, with good=0.
  - ACQUIRE, at each boundary: the frame is good if vcnt+1 = V_TOTAL and line_bad=0 (including the current line).
    - Good frame: good++. When good reaches LOCK_FRAMES → LOCKED.
    - Bad frame: good=0.
  - LOCKED: any bad line length, or bad frame length at a boundary, → SEARCH. Pulse ERR and clear LOCKED.
  - Any state: hcnt reaching 4095 → SEARCH, with ERR pulsed if the state was LOCKED.
- FRAME_START pulses at a boundary whose resulting state is LOCKED, including the boundary that achieves lock.
- ACTIVE = LOCKED and H_SYNC+H_BACK ≤ hcnt < H_SYNC+H_BACK+H_ACTIVE and the matching condition on vcnt.
  - X = hcnt-(H_SYNC+H_BACK) and Y = vcnt-(V_SYNC+V_BACK), both modulo 2^12.

## Timing
- All outputs are registered.
- Effects of the PIX_EN cycle at edge n are visible after edge n+1.
- X/Y/ACTIVE describe the pixel sampled on the previous PIX_EN cycle. Total latency is 1 CLOCK_50 cycle.
- A HS fall sampled on PIX_EN cycle k:
  - hcnt=0 is visible after cycle k.
  - At the default parameters, X=0/ACTIVE=1 first appears 144 PIX_EN strobes later.
- A simultaneous line edge and VS fall count as a frame boundary on that same edge.
- Reset held low mid-frame discards all history. Relock needs a fresh first boundary plus LOCK_FRAMES good frames.
- ERR and FRAME_START never assert in the same cycle; ERR wins.

## Structure
- Package vga_timing_pkg holds:
  - the default timing constants (shared with the generator);
  - the state enum SEARCH/ACQUIRE/LOCKED;
  - the 12-bit counter width.
- Sub-module sync_edge_det is instantiated twice, for HS and VS.
  - It registers its input on PIX_EN and outputs a fall flag.
  - Its reset value is 1, so a sync held low at reset produces no edge.
- Counters, checks and the state machine live in the top module.

## Test plan
- Reset, then nominal 800×525 frames with PIX_EN every other cycle:
  - LOCKED rises at the third boundary;
  - FRAME_START pulses once per frame;
  - H_MEAS=800, V_MEAS=525.
- Locked, nominal frame:
  - hcnt 144, vcnt 35 → X=0, Y=0, ACTIVE=1;
  - hcnt 783 → X=639;
  - hcnt 784 → ACTIVE=0, X=0.
- Locked, one line of 801 pixels:
  - ERR pulses once, LOCKED=0, H_MEAS=801;
  - LOCKED returns at the third boundary after the error.
- HS held high for 4096 strobes while locked: ERR pulses, LOCKED=0, state SEARCH.
- PIX_EN low for 50 cycles mid-line: X/Y/hcnt hold, then resume with +1 on the next strobe.
- RESET_N low for one cycle mid-frame while locked:
  - all outputs 0 the next cycle;
  - a frame of 524 lines during acquisition resets good, delaying lock by one frame.
